lif_neuron_array: RTL and testbench

Parametrised array of leaky integrate-and-fire neurons that generalises the single 8-bit neuron to N independent channels. Each neuron has configurable width, leak shift, threshold, post-spike reset mode, a refractory period and saturating integration. A shared spike counter totals spikes across the array. The block sits between the input-current source (one current word per neuron) and the spike consumer or output pins, and is advanced one time step per `en` pulse.

---
 rtl/lif_pkg.sv | 28 ++
 rtl/lif_cell.sv | 62 ++++++
 rtl/lif_neuron_array.sv | 97 +++++++++
 tb/tb_lif_neuron_array.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants and the configuration record for the LIF neuron array.
// The config struct is max-width so one type serves every W/REF_W choice.
package lif_pkg;

  localparam int THRESH_RST    = 32;
  localparam int LEAK_RST      = 1;
  localparam int REF_RST       = 0;
  localparam int LEAK_W        = 3;
  localparam int CFG_MAX_W     = 32;
  localparam int CFG_MAX_REF_W = 16;

  typedef struct packed {
    logic [CFG_MAX_W-1:0]     threshold;
    logic [LEAK_W-1:0]        leak_shift;
    logic [CFG_MAX_REF_W-1:0] refractory;
    logic                     sub_mode;
  } lif_cfg_t;

  function automatic lif_cfg_t cfg_default();
    lif_cfg_t c;
    c.threshold  = CFG_MAX_W'(THRESH_RST);
    c.leak_shift = LEAK_W'(LEAK_RST);
    c.refractory = CFG_MAX_REF_W'(REF_RST);
    c.sub_mode   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: leak, saturating integrate, threshold,
// post-spike reset and refractory hold. Advances only on i_en.
module lif_cell
  import lif_pkg::*;
#(
  parameter int W     = 8,
  parameter int REF_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [W-1:0]      i_current,
  input  logic [W-1:0]      i_threshold,
  input  logic [LEAK_W-1:0] i_leak_shift,
  input  logic [REF_W-1:0]  i_refractory,
  input  logic              i_sub_mode,
  output logic [W-1:0]      o_state,
  output logic              o_spike
);

  logic [W-1:0]     r_state;
  logic [REF_W-1:0] r_ref_cnt;
  logic             r_spike;

  logic [W-1:0] w_kept;
  logic [W:0]   w_sum_full;
  logic [W-1:0] w_sum;
  logic         w_fire;
  logic [W-1:0] w_post_spike;

  // A shift of 0 leaks everything (state - state), so kept is 0 there.
  assign w_kept       = r_state - (r_state >> i_leak_shift);
  assign w_sum_full   = {1'b0, w_kept} + {1'b0, i_current};
  assign w_sum        = w_sum_full[W] ? {W{1'b1}} : w_sum_full[W-1:0];
  assign w_fire       = (w_sum >= i_threshold);
  assign w_post_spike = i_sub_mode ? (w_sum - i_threshold) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_ref_cnt <= '0;
      r_spike   <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      if (i_en) begin
        if (r_ref_cnt != '0) begin
          r_ref_cnt <= r_ref_cnt - REF_W'(1);
        end else if (w_fire) begin
          r_spike   <= 1'b1;
          r_state   <= w_post_spike;
          r_ref_cnt <= i_refractory;
        end else begin
          r_state <= w_sum;
        end
      end
    end
  end

  assign o_state = r_state;
  assign o_spike = r_spike;

endmodule

// File: rtl/lif_neuron_array.sv
// N independent LIF neurons sharing one config register set, plus a
// saturating counter of all spikes emitted by the array.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int REF_W = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N*W-1:0]    current,
  input  logic              cfg_we,
  input  logic [W-1:0]      cfg_threshold,
  input  logic [LEAK_W-1:0] cfg_leak_shift,
  input  logic [REF_W-1:0]  cfg_refractory,
  input  logic              cfg_sub_mode,
  input  logic              count_clr,
  output logic [N*W-1:0]    state_out,
  output logic [N-1:0]      spike,
  output logic [CNT_W-1:0]  spike_count
);

  localparam int POP_W = $clog2(N + 1);

  lif_cfg_t         r_cfg;
  logic [CNT_W-1:0] r_count;

  logic [W-1:0]     w_threshold;
  logic [REF_W-1:0] w_refractory;
  logic             w_cfg_unused;
  logic [N-1:0]     w_spike;
  logic [POP_W-1:0] w_pop;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;

  // Fields are stored zero-extended; only the low W / REF_W bits matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg <= cfg_default();
    end else if (cfg_we) begin
      r_cfg.threshold  <= CFG_MAX_W'(cfg_threshold);
      r_cfg.leak_shift <= cfg_leak_shift;
      r_cfg.refractory <= CFG_MAX_REF_W'(cfg_refractory);
      r_cfg.sub_mode   <= cfg_sub_mode;
    end
  end

  assign w_threshold  = r_cfg.threshold[W-1:0];
  assign w_refractory = r_cfg.refractory[REF_W-1:0];
  assign w_cfg_unused = ^r_cfg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      lif_cell #(
        .W     (W),
        .REF_W (REF_W)
      ) u_cell (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (en),
        .i_current    (current[gi*W +: W]),
        .i_threshold  (w_threshold),
        .i_leak_shift (r_cfg.leak_shift),
        .i_refractory (w_refractory),
        .i_sub_mode   (r_cfg.sub_mode),
        .o_state      (state_out[gi*W +: W]),
        .o_spike      (w_spike[gi])
      );
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + POP_W'(w_spike[i]);
    end
  end

  assign w_cnt_sum  = {1'b0, r_count} + (CNT_W+1)'(w_pop);
  assign w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

  // Clear wins over the spikes currently on the output.
  always_ff @(posedge clk) begin
    if (!rst_n || count_clr) begin
      r_count <= '0;
    end else begin
      r_count <= w_cnt_next;
    end
  end

  assign spike       = w_spike;
  assign spike_count = r_count;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed and randomized checks of lif_neuron_array against an integer
// reference model; a second instance with a 4-bit counter exercises saturation.
module tb_lif_neuron_array;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int REF_W   = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [N*W-1:0]     current;
  logic               cfg_we;
  logic [W-1:0]       cfg_threshold;
  logic [2:0]         cfg_leak_shift;
  logic [REF_W-1:0]   cfg_refractory;
  logic               cfg_sub_mode;
  logic               count_clr;
  logic [N*W-1:0]     state_out,   state_out_s;
  logic [N-1:0]       spike,       spike_s;
  logic [CNT_W-1:0]   spike_count;
  logic [CNT_W_S-1:0] spike_count_s;

  int checks = 0;
  int errors = 0;

  int     m_state [N];
  int     m_ref   [N];
  int     m_spike [N];
  int     m_thr, m_ls, m_refl, m_sub;
  longint m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  lif_neuron_array #(.N(N), .W(W), .REF_W(REF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .cfg_we(cfg_we),
    .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refractory(cfg_refractory), .cfg_sub_mode(cfg_sub_mode),
    .count_clr(count_clr), .state_out(state_out), .spike(spike),
    .spike_count(spike_count)
  );

  lif_neuron_array #(.N(N), .W(W), .REF_W(REF_W), .CNT_W(CNT_W_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .cfg_we(cfg_we),
    .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refractory(cfg_refractory), .cfg_sub_mode(cfg_sub_mode),
    .count_clr(count_clr), .state_out(state_out_s), .spike(spike_s),
    .spike_count(spike_count_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_ref[i] = 0; m_spike[i] = 0;
    end
    m_thr = 32; m_ls = 1; m_refl = 0; m_sub = 0;
    m_cnt = 0; m_cnt_s = 0;
  endfunction

  // One clock edge of the array as described by the neuron rules.
  function automatic void model_step();
    int pop = 0;
    for (int i = 0; i < N; i++) pop += m_spike[i];
    m_cnt   = count_clr ? 0 : sat(m_cnt + pop, (64'd1 << CNT_W) - 1);
    m_cnt_s = count_clr ? 0 : sat(m_cnt_s + pop, (64'd1 << CNT_W_S) - 1);
    for (int i = 0; i < N; i++) begin
      int cur, kept, sum;
      cur = int'(current[i*W +: W]);
      m_spike[i] = 0;
      if (!en) continue;
      if (m_ref[i] > 0) begin
        m_ref[i]--;
        continue;
      end
      kept = m_state[i] - (m_state[i] / (1 << m_ls));
      sum  = int'(sat(kept + cur, 255));
      if (sum >= m_thr) begin
        m_spike[i] = 1;
        m_state[i] = m_sub ? sum - m_thr : 0;
        m_ref[i]   = m_refl;
      end else begin
        m_state[i] = sum;
      end
    end
    if (cfg_we) begin
      m_thr = int'(cfg_threshold); m_ls = int'(cfg_leak_shift);
      m_refl = int'(cfg_refractory); m_sub = int'(cfg_sub_mode);
    end
  endfunction

  task automatic check_all(input string where);
    logic [N-1:0] ev;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_spike[i][0];
      check($sformatf("%s state[%0d]", where, i), 64'(state_out[i*W +: W]), 64'(m_state[i]));
    end
    check($sformatf("%s spike", where), 64'(spike), 64'(ev));
    check($sformatf("%s count", where), 64'(spike_count), 64'(m_cnt));
    check($sformatf("%s count_small", where), 64'(spike_count_s), 64'(m_cnt_s));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_step();
    check_all(where);
  endtask

  task automatic set_idle();
    en = 1'b0; cfg_we = 1'b0; count_clr = 1'b0; current = '0;
    cfg_threshold = '0; cfg_leak_shift = '0; cfg_refractory = '0; cfg_sub_mode = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    step("reset");
    rst_n = 1'b1;
  endtask

  task automatic load_cfg(input int thr, input int ls, input int refl, input int sub);
    cfg_threshold = W'(thr); cfg_leak_shift = 3'(ls);
    cfg_refractory = REF_W'(refl); cfg_sub_mode = sub[0];
    cfg_we = 1'b1; en = 1'b0;
    step("cfg");
    cfg_we = 1'b0;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    step("por");

    // Defaults, neuron 0 at current 20: 20, 30, spike/0, repeating.
    do_reset();
    current = 32'd20; en = 1'b1;
    step("dflt1"); check("dflt1 literal", 64'(state_out[7:0]), 64'd20);
    step("dflt2"); check("dflt2 literal", 64'(state_out[7:0]), 64'd30);
    step("dflt3"); check("dflt3 literal spike", 64'(spike[0]), 64'd1);
    step("dflt4"); step("dflt5"); step("dflt6");

    // Subtract-threshold mode.
    do_reset();
    load_cfg(32, 1, 0, 1);
    current = 32'd20; en = 1'b1;
    step("sub1"); step("sub2");
    step("sub3"); check("sub3 literal", 64'(state_out[7:0]), 64'd3);
    step("sub4"); check("sub4 literal", 64'(state_out[7:0]), 64'd22);

    // Refractory 2: current ignored while refractory.
    do_reset();
    load_cfg(32, 1, 2, 0);
    current = 32'd40; en = 1'b1;
    step("ref1");
    current = 32'($urandom_range(0, 255)); step("ref2");
    current = 32'($urandom_range(0, 255)); step("ref3");
    current = 32'd40; step("ref4");
    check("ref4 literal spike", 64'(spike[0]), 64'd1);

    // Saturation at the top of the state range.
    do_reset();
    load_cfg(255, 7, 0, 0);
    current = 32'd200; en = 1'b1;
    step("satst1"); step("satst2");
    check("satst2 literal spike", 64'(spike[0]), 64'd1);

    // en gating.
    do_reset();
    current = 32'd10;
    en = 1'b1; step("en1");
    en = 1'b0; step("en0");
    en = 1'b1; step("en1b");
    check("en1b literal", 64'(state_out[7:0]), 64'd15);

    // Config write coinciding with a step uses the old threshold.
    do_reset();
    current = 32'd10; en = 1'b1;
    cfg_threshold = 8'd5; cfg_leak_shift = 3'd1; cfg_refractory = '0; cfg_sub_mode = 1'b0;
    cfg_we = 1'b1; step("cfgstep");
    cfg_we = 1'b0; step("cfgnext");
    check("cfgnext literal spike", 64'(spike[0]), 64'd1);

    // All neurons firing: counter steps by 4, small one saturates, clear wins.
    do_reset();
    current = {N{8'd255}}; en = 1'b1;
    for (int k = 0; k < 6; k++) step($sformatf("cnt%0d", k));
    check("cnt small literal", 64'(spike_count_s), 64'd15);
    count_clr = 1'b1; step("clr");
    check("clr literal", 64'(spike_count), 64'd0);
    count_clr = 1'b0; step("postclr");

    // Randomized traffic including config changes, clears and resets.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      en        = ($urandom_range(0, 3) != 0);
      current   = N*W'($urandom);
      count_clr = ($urandom_range(0, 19) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_threshold  = W'($urandom_range(0, 255));
      cfg_leak_shift = 3'($urandom_range(0, 7));
      cfg_refractory = REF_W'($urandom_range(0, 7));
      cfg_sub_mode   = 1'($urandom_range(0, 1));
      step($sformatf("rand%0d", k));
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
